// File: rtl/alien_swarm_ctrl.sv
// Alien swarm controller: holds the alive grid and moves the formation on frame ticks.
// It marches sideways, drops one row at a wall, and applies hits and shot requests.
// All outputs are registered; a hit, step or shot grant shows up one cycle after its input.
module alien_swarm_ctrl #(
  parameter int NUM_ROWS        = 3,
  parameter int NUM_COLS        = 5,
  parameter int ALIEN_SPACING_X = 64,
  parameter int ALIEN_SPACING_Y = 32,
  parameter int ALIEN_W         = 16,
  parameter int START_X         = 100,
  parameter int START_Y         = 50,
  parameter int STEP_X          = 8,
  parameter int STEP_Y          = 16,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 640,
  parameter int Y_LIMIT         = 400,
  parameter int BASE_PERIOD     = 60,
  parameter int MIN_PERIOD      = 4,
  parameter int KILL_STEP       = 3,
  parameter int LEVEL_STEP      = 5
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     frame_tick,
  input  logic                                     start,
  input  logic                                     hit_valid,
  input  logic [$clog2(NUM_ROWS)-1:0]              hit_row,
  input  logic [$clog2(NUM_COLS)-1:0]              hit_col,
  input  logic                                     fire_req,
  input  logic [$clog2(NUM_COLS)-1:0]              fire_col,
  output logic [NUM_ROWS*NUM_COLS-1:0]             alive_matrix,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]   alive_count,
  output logic [15:0]                              origin_x,
  output logic [15:0]                              origin_y,
  output logic                                     direction,
  output logic [3:0]                               level,
  output logic                                     step_pulse,
  output logic                                     fire_grant,
  output logic [$clog2(NUM_ROWS)-1:0]              fire_row,
  output logic [15:0]                              fire_x,
  output logic [15:0]                              fire_y,
  output logic                                     wave_clear,
  output logic                                     invaded
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int NA = NUM_ROWS * NUM_COLS;
  localparam int AW = $clog2(NUM_ROWS * NUM_COLS + 1);
  localparam int IW = $clog2(NA);

  typedef enum logic [2:0] {IDLE, MARCH, DESCEND, CLEAR, INVADED} state_t;

  state_t              state, next_state;
  logic [15:0]         frame_cnt;
  logic                active, start_now, step_now, step_descend;
  logic                hit_in_range, hit_ok, kill_last;
  logic                fire_col_hit, fire_ok;
  logic [IW-1:0]       hit_idx;
  logic [NUM_COLS-1:0] col_any;
  logic [NUM_ROWS-1:0] row_any;
  logic [RW-1:0]       fire_r;
  int                  lcol, rcol, brow, period, left_x, right_x, march_x, descend_y;

  // Occupancy scan of the grid plus the movement/period arithmetic (signed, no underflow).
  always_comb begin
    col_any      = '0;
    row_any      = '0;
    fire_r       = '0;
    fire_col_hit = 1'b0;
    lcol         = 0;
    rcol         = 0;
    brow         = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (alive_matrix[r*NUM_COLS + c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
          // Ascending row order leaves the lowest (largest index) alive row.
          if (int'(fire_col) == c) begin
            fire_col_hit = 1'b1;
            fire_r       = RW'(r);
          end
        end
      end
    end
    for (int c = NUM_COLS - 1; c >= 0; c--) if (col_any[c]) lcol = c;
    for (int c = 0; c < NUM_COLS; c++)      if (col_any[c]) rcol = c;
    for (int r = 0; r < NUM_ROWS; r++)      if (row_any[r]) brow = r;

    period = BASE_PERIOD - KILL_STEP * (NA - int'(alive_count))
             - LEVEL_STEP * (int'(level) - 1);
    if (period < MIN_PERIOD) period = MIN_PERIOD;

    left_x    = int'(origin_x) + lcol * ALIEN_SPACING_X;
    right_x   = int'(origin_x) + rcol * ALIEN_SPACING_X + ALIEN_W;
    march_x   = direction ? int'(origin_x) + STEP_X : int'(origin_x) - STEP_X;
    descend_y = int'(origin_y) + STEP_Y;

    active       = (state == MARCH) || (state == DESCEND);
    start_now    = start && ((state == IDLE) || (state == CLEAR) || (state == INVADED));
    hit_in_range = (int'(hit_row) < NUM_ROWS) && (int'(hit_col) < NUM_COLS);
    hit_idx      = IW'(int'(hit_row) * NUM_COLS + int'(hit_col));
    hit_ok       = active && hit_valid && hit_in_range && alive_matrix[hit_idx];
    kill_last    = hit_ok && (alive_count == AW'(1));
    fire_ok      = active && fire_req && fire_col_hit;
  end

  // Next-state logic; the last kill wins over a step or descend on the same cycle.
  always_comb begin
    next_state   = state;
    step_now     = 1'b0;
    step_descend = 1'b0;
    case (state)
      IDLE, CLEAR, INVADED: begin
        if (start) next_state = MARCH;
      end
      MARCH: begin
        if (frame_tick && (int'(frame_cnt) >= period - 1)) begin
          step_now     = 1'b1;
          step_descend = direction ? (right_x + STEP_X > X_MAX) : (left_x - STEP_X < X_MIN);
          if (step_descend) next_state = DESCEND;
        end
        if (kill_last) next_state = CLEAR;
      end
      DESCEND: begin
        next_state = (descend_y + brow * ALIEN_SPACING_Y + ALIEN_W >= Y_LIMIT) ? INVADED : MARCH;
        if (kill_last) next_state = CLEAR;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Grid, formation position, counters and the registered pulses/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_matrix <= '0;
      alive_count  <= '0;
      origin_x     <= 16'(START_X);
      origin_y     <= 16'(START_Y);
      direction    <= 1'b1;
      level        <= '0;
      frame_cnt    <= '0;
      step_pulse   <= 1'b0;
      fire_grant   <= 1'b0;
      fire_row     <= '0;
      fire_x       <= '0;
      fire_y       <= '0;
      wave_clear   <= 1'b0;
      invaded      <= 1'b0;
    end else begin
      step_pulse <= step_now;
      wave_clear <= (next_state == CLEAR) && (state != CLEAR);
      fire_grant <= fire_ok;
      if (fire_ok) begin
        fire_row <= fire_r;
        fire_x   <= 16'(int'(origin_x) + int'(fire_col) * ALIEN_SPACING_X);
        fire_y   <= 16'(int'(origin_y) + int'(fire_r) * ALIEN_SPACING_Y);
      end
      if (start_now) begin
        alive_matrix <= '1;
        alive_count  <= AW'(NA);
        origin_x     <= 16'(START_X);
        origin_y     <= 16'(START_Y);
        direction    <= 1'b1;
        frame_cnt    <= '0;
        invaded      <= 1'b0;
        if (state == INVADED)  level <= 4'd1;
        else if (level != 4'd15) level <= level + 4'd1;
      end else begin
        if (hit_ok) begin
          alive_matrix[hit_idx] <= 1'b0;
          alive_count           <= alive_count - AW'(1);
        end
        if ((state == MARCH) && frame_tick) frame_cnt <= step_now ? '0 : frame_cnt + 16'd1;
        if (step_now && !step_descend) origin_x <= 16'(march_x);
        if (state == DESCEND) begin
          origin_y  <= 16'(descend_y);
          direction <= ~direction;
        end
        if ((next_state == INVADED) && (state != INVADED)) invaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alien_swarm_ctrl.sv
// Self-checking bench for alien_swarm_ctrl: reset, marching, hits, shots, clear and invasion.
// Expected values come from constants and scoreboard queues filled as stimulus is driven.
module tb_alien_swarm_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        frame_tick = 1'b0, start = 1'b0, hit_valid = 1'b0, fire_req = 1'b0;
  logic [1:0]  hit_row = '0;
  logic [2:0]  hit_col = '0, fire_col = '0;
  logic [14:0] alive_matrix;
  logic [3:0]  alive_count, level;
  logic [15:0] origin_x, origin_y, fire_x, fire_y;
  logic        direction, step_pulse, fire_grant, wave_clear, invaded;
  logic [1:0]  fire_row;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        grant;
    logic [1:0]  row;
    logic [15:0] x;
    logic [15:0] y;
  } fire_exp_t;

  fire_exp_t fire_q[$];
  int        count_q[$];

  localparam logic [93:0] RESET_SNAP = {15'd0, 4'd0, 16'd100, 16'd50, 1'b1, 4'd0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};

  alien_swarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .fire_req(fire_req), .fire_col(fire_col),
    .alive_matrix(alive_matrix), .alive_count(alive_count),
    .origin_x(origin_x), .origin_y(origin_y), .direction(direction), .level(level),
    .step_pulse(step_pulse), .fire_grant(fire_grant), .fire_row(fire_row),
    .fire_x(fire_x), .fire_y(fire_y), .wave_clear(wave_clear), .invaded(invaded)
  );

  always #5 clk = ~clk;

  function automatic logic [93:0] snap();
    return {alive_matrix, alive_count, origin_x, origin_y, direction, level,
            step_pulse, fire_grant, wave_clear, invaded, fire_row, fire_x, fire_y};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hit(input int r, input int c);
    hit_valid = 1'b1;
    hit_row   = 2'(r);
    hit_col   = 3'(c);
    cycle();
    hit_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n, output int pulses);
    pulses     = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (step_pulse) pulses++;
    end
    frame_tick = 1'b0;
  endtask

  task automatic ticks_to_step(input int budget, output int used);
    used       = -1;
    frame_tick = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      cycle();
      if (step_pulse) begin
        used = i;
        break;
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic start_wave();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    fire_exp_t e;
    rst_n = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (snap() !== RESET_SNAP) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", snap(), RESET_SNAP);
    end
    rst_n = 1'b1;
    cycle();
    fire_q.push_back('{1'b0, 2'd0, 16'd0, 16'd0});
    fire_req = 1'b1;
    fire_col = 3'd0;
    cycle();
    fire_req = 1'b0;
    e = fire_q.pop_front();
    n_checks++;
    if (fire_grant !== e.grant) begin
      n_fail++;
      $display("FAIL idle_fire: got %0d expected %0d", fire_grant, e.grant);
    end
    count_q.push_back(0);
    drive_hit(0, 0);
    n_checks++;
    if (alive_count !== 4'(count_q.pop_front())) begin
      n_fail++;
      $display("FAIL idle_hit: got %0d expected 0", alive_count);
    end
  endtask

  task automatic test_start();
    start_wave();
    n_checks++;
    if (alive_matrix !== 15'h7fff || alive_count !== 4'd15 || level !== 4'd1) begin
      n_fail++;
      $display("FAIL start_grid: got m=%h c=%0d l=%0d expected 7fff 15 1",
               alive_matrix, alive_count, level);
    end
    n_checks++;
    if (origin_x !== 16'd100 || origin_y !== 16'd50 || direction !== 1'b1) begin
      n_fail++;
      $display("FAIL start_origin: got (%0d,%0d,%0d) expected (100,50,1)",
               origin_x, origin_y, direction);
    end
  endtask

  task automatic test_march();
    int p;
    run_ticks(60, p);
    n_checks++;
    if (p != 1 || origin_x !== 16'd108) begin
      n_fail++;
      $display("FAIL first_step: got pulses=%0d x=%0d expected 1 108", p, origin_x);
    end
    run_ticks(32 * 60, p);
    n_checks++;
    if (p != 32 || origin_x !== 16'd364 || origin_y !== 16'd50) begin
      n_fail++;
      $display("FAIL step33: got pulses=%0d x=%0d y=%0d expected 32 364 50", p, origin_x, origin_y);
    end
    run_ticks(60, p);
    cycle();
    n_checks++;
    if (p != 1 || origin_x !== 16'd364 || origin_y !== 16'd66 || direction !== 1'b0) begin
      n_fail++;
      $display("FAIL descend: got p=%0d x=%0d y=%0d d=%0d expected 1 364 66 0",
               p, origin_x, origin_y, direction);
    end
  endtask

  task automatic test_hit();
    int used;
    int hits_r[4] = '{2, 2, 3, 0};
    int hits_c[4] = '{3, 3, 0, 5};
    for (int i = 0; i < 4; i++) begin
      count_q.push_back(14);
      drive_hit(hits_r[i], hits_c[i]);
      n_checks++;
      if (alive_count !== 4'(count_q.pop_front())) begin
        n_fail++;
        $display("FAIL hit_count[%0d]: got %0d expected 14", i, alive_count);
      end
    end
    n_checks++;
    if (alive_matrix !== 15'h5fff) begin
      n_fail++;
      $display("FAIL hit_matrix: got %h expected 5fff", alive_matrix);
    end
    ticks_to_step(200, used);
    n_checks++;
    if (used != 57 || origin_x !== 16'd356) begin
      n_fail++;
      $display("FAIL period_one_kill: got ticks=%0d x=%0d expected 57 356", used, origin_x);
    end
  endtask

  task automatic test_fire();
    fire_exp_t e;
    int cols[2] = '{3, 4};
    fire_q.push_back('{1'b1, 2'd1, 16'd548, 16'd98});
    fire_q.push_back('{1'b1, 2'd2, 16'd612, 16'd130});
    for (int i = 0; i < 2; i++) begin
      fire_req = 1'b1;
      fire_col = 3'(cols[i]);
      cycle();
      e = fire_q.pop_front();
      n_checks++;
      if ({fire_grant, fire_row, fire_x, fire_y} !== e) begin
        n_fail++;
        $display("FAIL fire_col%0d: got g=%0d r=%0d x=%0d y=%0d expected g=%0d r=%0d x=%0d y=%0d",
                 cols[i], fire_grant, fire_row, fire_x, fire_y, e.grant, e.row, e.x, e.y);
      end
    end
    fire_req = 1'b0;
    start_wave();
    n_checks++;
    if (level !== 4'd1 || alive_count !== 4'd14) begin
      n_fail++;
      $display("FAIL start_in_march: got l=%0d c=%0d expected 1 14", level, alive_count);
    end
  endtask

  task automatic test_col_kill();
    int p;
    fire_exp_t e;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    start_wave();
    for (int r = 0; r < 3; r++) drive_hit(r, 4);
    n_checks++;
    if (alive_count !== 4'd12) begin
      n_fail++;
      $display("FAIL col_kill_count: got %0d expected 12", alive_count);
    end
    p = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      cycle();
      if (step_pulse) p++;
      if (direction == 1'b0) break;
    end
    frame_tick = 1'b0;
    n_checks++;
    if (p != 42 || origin_x !== 16'd428 || origin_y !== 16'd66 || direction !== 1'b0) begin
      n_fail++;
      $display("FAIL narrow_extent: got steps=%0d x=%0d y=%0d d=%0d expected 42 428 66 0",
               p, origin_x, origin_y, direction);
    end
    fire_q.push_back('{1'b0, 2'd0, 16'd0, 16'd0});
    fire_q.push_back('{1'b1, 2'd2, 16'd620, 16'd130});
    for (int i = 0; i < 2; i++) begin
      fire_req = 1'b1;
      fire_col = (i == 0) ? 3'd4 : 3'd3;
      cycle();
      e = fire_q.pop_front();
      n_checks++;
      if (fire_grant !== e.grant || (e.grant && {fire_row, fire_x, fire_y} !== {e.row, e.x, e.y})) begin
        n_fail++;
        $display("FAIL fire_after_col_kill[%0d]: got g=%0d r=%0d x=%0d y=%0d expected g=%0d r=%0d x=%0d y=%0d",
                 i, fire_grant, fire_row, fire_x, fire_y, e.grant, e.row, e.x, e.y);
      end
    end
    fire_req = 1'b0;
  endtask

  task automatic test_clear();
    int clears, p, used, k;
    clears = 0;
    k = 12;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        k--;
        count_q.push_back(k);
        drive_hit(r, c);
        if (wave_clear) clears++;
        n_checks++;
        if (alive_count !== 4'(count_q.pop_front())) begin
          n_fail++;
          $display("FAIL clear_count r%0d c%0d: got %0d expected %0d", r, c, alive_count, k);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (wave_clear) clears++;
    end
    n_checks++;
    if (clears != 1 || alive_matrix !== 15'd0) begin
      n_fail++;
      $display("FAIL wave_clear: got pulses=%0d m=%h expected 1 0000", clears, alive_matrix);
    end
    run_ticks(100, p);
    n_checks++;
    if (p != 0) begin
      n_fail++;
      $display("FAIL clear_frozen: got %0d steps expected 0", p);
    end
    start_wave();
    n_checks++;
    if (level !== 4'd2 || alive_count !== 4'd15 || origin_x !== 16'd100 ||
        origin_y !== 16'd50 || direction !== 1'b1) begin
      n_fail++;
      $display("FAIL level2_start: got l=%0d c=%0d (%0d,%0d) d=%0d expected 2 15 (100,50) 1",
               level, alive_count, origin_x, origin_y, direction);
    end
    ticks_to_step(200, used);
    n_checks++;
    if (used != 55) begin
      n_fail++;
      $display("FAIL period_level2: got %0d expected 55", used);
    end
  endtask

  task automatic test_invade();
    int p;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) drive_hit(r, c);
    frame_tick = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      cycle();
      if (invaded) break;
    end
    frame_tick = 1'b0;
    n_checks++;
    if (invaded !== 1'b1 || origin_y !== 16'd322) begin
      n_fail++;
      $display("FAIL invasion: got inv=%0d y=%0d expected 1 322", invaded, origin_y);
    end
    run_ticks(200, p);
    n_checks++;
    if (p != 0 || origin_y !== 16'd322 || invaded !== 1'b1) begin
      n_fail++;
      $display("FAIL invaded_frozen: got steps=%0d y=%0d inv=%0d expected 0 322 1", p, origin_y, invaded);
    end
    start_wave();
    n_checks++;
    if (level !== 4'd1 || invaded !== 1'b0 || alive_count !== 4'd15) begin
      n_fail++;
      $display("FAIL restart_after_invade: got l=%0d inv=%0d c=%0d expected 1 0 15",
               level, invaded, alive_count);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    run_ticks(5, p);
    hit_valid  = 1'b1;
    hit_row    = 2'd0;
    hit_col    = 3'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (snap() !== RESET_SNAP) begin
      n_fail++;
      $display("FAIL reset_mid_wave: got %h expected %h", snap(), RESET_SNAP);
    end
    cycle();
    hit_valid  = 1'b0;
    frame_tick = 1'b0;
    rst_n      = 1'b1;
    cycle();
    n_checks++;
    if (alive_count !== 4'd0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL after_reset_release: got c=%0d l=%0d expected 0 0", alive_count, level);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_march();
    test_hit();
    test_fire();
    test_col_kill();
    test_clear();
    test_invade();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
